// File: rtl/rca_seq_ctrl.sv
// Wide adder built from one shared 4-bit ripple-carry slice: one nibble per clock, LS nibble first.
// Optional subtract mode is compiled in with `define RCA_SEQ_SUB_EN (adds the op_sub port).
module rca_seq_ctrl #(
   parameter int NIBBLES = 4,
   localparam int W = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         op_cin,
`ifdef RCA_SEQ_SUB_EN
   input  logic         op_sub,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         busy,
   output logic [3:0]   add_a,
   output logic [3:0]   add_b,
   output logic         add_cin,
   input  logic [3:0]   add_s,
   input  logic         add_co
);

   localparam int CW = $clog2(NIBBLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  sum_sh;
   logic          carry;
   logic          cout_q;
   logic [CW-1:0] cnt;
   logic          accept;
   logic [3:0]    b_nib;

`ifdef RCA_SEQ_SUB_EN
   logic          sub_q;
   assign b_nib = sub_q ? ~b_sh[3:0] : b_sh[3:0];
`else
   assign b_nib = b_sh[3:0];
`endif

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = RUN;
         RUN:  if (cnt == CNT_LAST) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // in_ready is gated by rst_n so it reads 0 for the whole time reset is held
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      add_a     = 4'd0;
      add_b     = 4'd0;
      add_cin   = 1'b0;
      case (state)
         IDLE: in_ready = rst_n;
         RUN: begin
            busy    = 1'b1;
            add_a   = a_sh[3:0];
            add_b   = b_nib;
            add_cin = carry;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // cout has its own register so loading the initial carry at accept leaves the visible result untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         cnt    <= '0;
`ifdef RCA_SEQ_SUB_EN
         sub_q  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_sh  <= op_a;
                  b_sh  <= op_b;
                  cnt   <= '0;
`ifdef RCA_SEQ_SUB_EN
                  sub_q <= op_sub;
                  carry <= op_sub ? 1'b1 : op_cin;
`else
                  carry <= op_cin;
`endif
               end
            end
            RUN: begin
               sum_sh <= (sum_sh >> 4) | (W'(add_s) << (W - 4));
               carry  <= add_co;
               cout_q <= add_co;
               a_sh   <= a_sh >> 4;
               b_sh   <= b_sh >> 4;
               cnt    <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_sh;
   assign cout = cout_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Testbench for rca_seq_ctrl: directed and random operations checked against a plain-arithmetic model.
// Also exercises subtract mode when compiled with RCA_SEQ_SUB_EN.
module tb_rca_seq_ctrl;

   localparam int NIBBLES = 4;
   localparam int W = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         op_cin = 1'b0;
   logic         op_sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
   logic [3:0]   add_a;
   logic [3:0]   add_b;
   logic         add_cin;
   logic [3:0]   add_s;
   logic         add_co;

   int n_vectors = 0;
   int n_miscompares = 0;

   rca_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .op_a(op_a),
      .op_b(op_b),
      .op_cin(op_cin),
`ifdef RCA_SEQ_SUB_EN
      .op_sub(op_sub),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum(sum),
      .cout(cout),
      .busy(busy),
      .add_a(add_a),
      .add_b(add_b),
      .add_cin(add_cin),
      .add_s(add_s),
      .add_co(add_co)
   );

   // The shared 4-bit slice the sequencer drives
   assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vectors++;
      assert (obs === exp)
      else begin
         n_miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation: accept, NIBBLES run cycles, optional backpressure, release
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic sub, input int hold, input logic early_ready);
      logic [63:0] b_eff;
      logic [63:0] c0;
      logic [63:0] total;
      logic [63:0] mask;
      logic [63:0] exp_sum;
      logic [63:0] exp_cout;
      b_eff = sub ? {48'd0, ~b} : {48'd0, b};
      c0    = sub ? 64'd1 : {63'd0, cin};
      total = {48'd0, a} + b_eff + c0;
      exp_sum  = total & 64'hFFFF;
      exp_cout = (total >> W) & 64'd1;

      op_a = a; op_b = b; op_cin = cin; op_sub = sub;
      in_valid = 1'b1;
      out_ready = early_ready;
      checkOutput("in_ready_idle", {63'd0, in_ready}, 64'd1);
      tick();
      for (int i = 0; i < NIBBLES; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         op_a = W'($urandom);
         mask = (64'd1 << (4 * i)) - 64'd1;
         checkOutput("add_a", {60'd0, add_a}, ({48'd0, a} >> (4 * i)) & 64'hF);
         checkOutput("add_b", {60'd0, add_b}, (b_eff >> (4 * i)) & 64'hF);
         checkOutput("add_cin", {63'd0, add_cin},
                     ((({48'd0, a} & mask) + (b_eff & mask) + c0) >> (4 * i)) & 64'd1);
         checkOutput("busy_run", {63'd0, busy}, 64'd1);
         checkOutput("out_valid_run", {63'd0, out_valid}, 64'd0);
         checkOutput("in_ready_run", {63'd0, in_ready}, 64'd0);
         tick();
      end
      in_valid = 1'b0;
      checkOutput("out_valid_done", {63'd0, out_valid}, 64'd1);
      checkOutput("sum", {48'd0, sum}, exp_sum);
      checkOutput("cout", {63'd0, cout}, exp_cout);
      checkOutput("add_a_done", {60'd0, add_a}, 64'd0);
      checkOutput("add_cin_done", {63'd0, add_cin}, 64'd0);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'(h % 2 == 0);
         op_a = W'($urandom);
         op_b = W'($urandom);
         tick();
         checkOutput("out_valid_hold", {63'd0, out_valid}, 64'd1);
         checkOutput("in_ready_hold", {63'd0, in_ready}, 64'd0);
         checkOutput("sum_hold", {48'd0, sum}, exp_sum);
         checkOutput("cout_hold", {63'd0, cout}, exp_cout);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("out_valid_after", {63'd0, out_valid}, 64'd0);
      checkOutput("in_ready_after", {63'd0, in_ready}, 64'd1);
      checkOutput("busy_after", {63'd0, busy}, 64'd0);
      checkOutput("sum_after", {48'd0, sum}, exp_sum);
      checkOutput("cout_after", {63'd0, cout}, exp_cout);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
      checkOutput({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
      checkOutput({tag, "_sum"}, {48'd0, sum}, 64'd0);
      checkOutput({tag, "_cout"}, {63'd0, cout}, 64'd0);
      checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd0);
      checkOutput({tag, "_add"}, {55'd0, add_a, add_b, add_cin}, 64'd0);
   endtask

   initial begin
      // Power-on reset held for three cycles
      rst_n = 1'b0;
      tick();
      tick();
      tick();
      checkResetOutputs("reset");
      rst_n = 1'b1;
      #1;
      checkOutput("in_ready_release", {63'd0, in_ready}, 64'd1);

      applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
      applyStimulus(16'hABCD, 16'h9876, 1'b1, 1'b0, 5, 1'b0);
      applyStimulus(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 0, 1'b1);

      // Reset after two nibbles of an operation
      op_a = 16'h5678; op_b = 16'h1111; op_cin = 1'b0; op_sub = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      checkOutput("busy_before_reset", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midrun");
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("out_valid_no_stale", {63'd0, out_valid}, 64'd0);
      applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

`ifdef RCA_SEQ_SUB_EN
      applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
      applyStimulus(16'h0007, 16'h0005, 1'b0, 1'b1, 2, 1'b0);
`endif

      for (int r = 0; r < 20; r++) begin
`ifdef RCA_SEQ_SUB_EN
         applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
`else
         applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                       1'b0, $urandom_range(0, 3), 1'b0);
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/rca_seq_ctrl.md
# rca_seq_ctrl

Multi-cycle wide-add sequencer that reuses one 4-bit ripple-carry adder slice to add two `4*NIBBLES`-bit operands. It processes one nibble per clock, least significant first, and chains the carry through an internal register. It sits between a valid/ready operand source and a valid/ready result sink, and drives the shared 4-bit adder through a dedicated port group.

## Interface
- `NIBBLES`, default 4: operand width in nibbles (≥1); data width `W = 4*NIBBLES`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand request.
- `in_ready` out 1: block can accept an operand.
- `op_a` in W: addend A.
- `op_b` in W: addend B.
- `op_cin` in 1: carry-in.
- `out_valid` out 1: result available.
- `out_ready` in 1: sink accepts the result.
- `sum` out W: result.
- `cout` out 1: carry out of the MS nibble.
- `busy` out 1: high in RUN or DONE.
- `add_a` out 4: adder slice A.
- `add_b` out 4: adder slice B.
- `add_cin` out 1: adder slice carry-in.
- `add_s` in 4: adder slice sum (combinational from `add_*`).
- `add_co` in 1: adder slice carry-out (bit 3 carry).

## Operation
- FSM states IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE.** `in_ready=1`. On `in_valid & in_ready`:
  - latch `op_a` and `op_b` into shift registers;
  - `carry <= op_cin`;
  - `cnt <= 0`;
  - go to RUN.
- **RUN.** Drive `add_a = a_sh[3:0]`, `add_b = b_sh[3:0]`, `add_cin = carry`. Each edge:
  - `sum_sh <= {add_s, sum_sh[W-1:4]}`;
  - `carry <= add_co`;
  - `a_sh` and `b_sh` shift right by 4;
  - `cnt++`.
  - When `cnt == NIBBLES-1` at the edge, go to DONE.
- **DONE.** `out_valid=1`, `sum = sum_sh`, `cout = carry`. On `out_ready`, go to IDLE.
- Outside RUN, `add_a`, `add_b` and `add_cin` are forced to 0.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- Arithmetic is modulo 2^W. `{cout, sum}` equals `op_a + op_b + op_cin` exactly.
- `cnt` width is `$clog2(NIBBLES)+1`. With `NIBBLES=1`, RUN lasts exactly one cycle.
- Reset mid-operation returns to IDLE immediately. The partial result is discarded and `out_valid` never asserts for that operation.

## Timing
- Reset values:
  - `in_ready=0` while `rst_n` is low, then 1 from IDLE;
  - `out_valid=0`, `sum=0`, `cout=0`, `busy=0`, `add_a=0`, `add_b=0`, `add_cin=0`.
- Latency: accept at edge k, `out_valid` high after edge k+NIBBLES.
- Minimum period per operation is NIBBLES+2 cycles: IDLE accept, NIBBLES in RUN, at least one in DONE.
- `sum` and `cout` change only during RUN. They are stable while `out_valid=1` and hold their value after the handshake until the next RUN.
- `out_ready` held high before DONE gives a one-cycle DONE.
- The adder slice path is combinational within one cycle. The block adds no pipeline stage on `add_s`/`add_co`.

## Configuration
- `RCA_SEQ_SUB_EN` defined:
  - adds input `op_sub` (1 bit), latched with the operands;
  - when `op_sub=1`: `add_b = ~b_sh[3:0]`, initial carry is 1, `op_cin` is ignored, and the result is `op_a - op_b`;
  - `cout=1` means no borrow.
- `RCA_SEQ_SUB_EN` undefined: the `op_sub` port is absent and the block is add-only.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles, then release → all outputs 0, `in_ready=1` on the first cycle after release.
- Basic add (`NIBBLES=4`): `0x1234 + 0x4321`, `cin=0` → `sum=0x5555`, `cout=0`, `out_valid` exactly 4 cycles after accept; `add_a` sequence 4,3,2,1.
- Full ripple: `0xFFFF + 0x0001`, `cin=0` → `sum=0x0000`, `cout=1`. Then `0xFFFF + 0x0000`, `cin=1` → same result.
- Backpressure: `out_ready=0` for 5 cycles in DONE with `in_valid=1` toggling → `sum` and `cout` held, `in_ready=0`, no new accept. Raising `out_ready` → IDLE next cycle.
- Reset mid-RUN: assert `rst_n=0` after 2 nibbles → immediate IDLE with outputs 0. Next op `0x00FF + 0x0001` → `0x0100`, `cout=0`.
- `RCA_SEQ_SUB_EN`:
  - `0x0005 - 0x0007` → `sum=0xFFFE`, `cout=0`;
  - `0x0007 - 0x0005` → `sum=0x0002`, `cout=1`.
